chunk_head_pipe: RTL and testbench

- Parametrised, pipelined successor of the chunk-head address stage in the TileAccumUnit read pipeline.
- For one accepted (bofs, aofs) pair, it walks config ids in [beg, end) and skips ids whose enable bit is clear.
- For each visited id it emits one memory-offset vector: mofs = global_mofs[id] + shuffled(bofs*bstride) + shuffled(aofs*astride).
- A two-stage multiply/accumulate pipeline sustains one output per cycle. Empty or fully-masked ranges complete without output.

---
 rtl/chunk_head_pkg.sv | 17 +
 rtl/chunk_head_pipe_next_cfg_finder.sv | 25 ++
 rtl/chunk_head_pipe.sv | 196 +++++++++++++++++++
 tb/tb_chunk_head_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_head_pkg.sv
// Shared defaults and FSM encoding for the chunk-head address pipeline.
package chunk_head_pkg;

  localparam int unsigned CFG_WORK_BW        = 16;
  localparam int unsigned CFG_VDIM           = 2;
  localparam int unsigned CFG_DIM            = 4;
  localparam int unsigned CFG_N_ICFG         = 4;
  localparam int unsigned CFG_STRIDE_FRAC_BW = 4;
  localparam int unsigned CFG_STRIDE_BW      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

endpackage

// File: rtl/chunk_head_pipe_next_cfg_finder.sv
// Priority search: lowest enabled config id in [i_lo, i_end), ids beyond N_ICFG never match.
module chunk_head_pipe_next_cfg_finder #(
  parameter int unsigned N_ICFG  = 4,
  parameter int unsigned ICFG_BW = 3
) (
  input  logic [N_ICFG-1:0]  i_mask,
  input  logic [ICFG_BW-1:0] i_lo,
  input  logic [ICFG_BW-1:0] i_end,
  output logic               o_found,
  output logic [ICFG_BW-1:0] o_id
);

  // Descending scan so the lowest qualifying id is the one left standing.
  always_comb begin
    o_found = 1'b0;
    o_id    = '0;
    for (int i = N_ICFG - 1; i >= 0; i--) begin
      if (i_mask[i] && (ICFG_BW'(i) >= i_lo) && (ICFG_BW'(i) < i_end)) begin
        o_found = 1'b1;
        o_id    = ICFG_BW'(i);
      end
    end
  end

endmodule

// File: rtl/chunk_head_pipe.sv
// Walks enabled config ids of a range and emits one scaled, shuffled, accumulated offset vector per id.
module chunk_head_pipe
  import chunk_head_pkg::*;
#(
  parameter int unsigned WBW     = CFG_WORK_BW,
  parameter int unsigned VDIM    = CFG_VDIM,
  parameter int unsigned DIM     = CFG_DIM,
  parameter int unsigned N_ICFG  = CFG_N_ICFG,
  parameter int unsigned SF_BW   = CFG_STRIDE_FRAC_BW,
  parameter int unsigned SS_BW   = CFG_STRIDE_BW,
  parameter int unsigned ICFG_BW = $clog2(N_ICFG + 1),
  parameter int unsigned DIM_BW  = $clog2(DIM)
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_abofs_rdy,
  output logic                                    i_abofs_ack,
  input  logic [VDIM-1:0][WBW-1:0]                i_bofs,
  input  logic [VDIM-1:0][WBW-1:0]                i_aofs,
  input  logic [ICFG_BW-1:0]                      i_beg,
  input  logic [ICFG_BW-1:0]                      i_end,
  input  logic [N_ICFG-1:0]                       i_cfg_en,
  input  logic [N_ICFG-1:0][DIM-1:0][WBW-1:0]     i_global_mofs,
  input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_global_bshufs,
  input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_global_ashufs,
  input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_bstrides_frac,
  input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_astrides_frac,
  input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_bstrides_shamt,
  input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_astrides_shamt,
  output logic                                    o_mofs_rdy,
  input  logic                                    o_mofs_ack,
  output logic [DIM-1:0][WBW-1:0]                 o_mofs,
  output logic [ICFG_BW-1:0]                      o_id,
  output logic                                    o_islast
);

  localparam int unsigned IDX_BW = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;

  fsm_e                            state_q, state_d;
  logic                            s1_vld_q, s1_vld_d;
  logic [ICFG_BW-1:0]              s1_id_q, s1_id_d;
  logic [VDIM-1:0][WBW-1:0]        s1_bprod_q, s1_bprod_d;
  logic [VDIM-1:0][WBW-1:0]        s1_aprod_q, s1_aprod_d;
  logic [VDIM-1:0][DIM_BW-1:0]     s1_bshuf_q, s1_bshuf_d;
  logic [VDIM-1:0][DIM_BW-1:0]     s1_ashuf_q, s1_ashuf_d;
  logic                            mofs_rdy_q, mofs_rdy_d;
  logic [DIM-1:0][WBW-1:0]         mofs_q, mofs_d;
  logic [ICFG_BW-1:0]              id_q, id_d;
  logic                            islast_q, islast_d;

  logic                            first_found, nxt_found;
  logic [ICFG_BW-1:0]              first_id, nxt_id, ld_id;
  logic [IDX_BW-1:0]               ld_idx, s1_idx;
  logic                            ld, s1_adv;
  logic [DIM-1:0][WBW-1:0]         acc;

  function automatic logic [WBW-1:0] scale(input logic [WBW-1:0]   ofs,
                                           input logic [SF_BW-1:0] frac,
                                           input logic [SS_BW-1:0] shamt);
    logic [WBW-1:0] m;
    m = ofs * WBW'(frac);
    return m << shamt;
  endfunction

  chunk_head_pipe_next_cfg_finder #(.N_ICFG(N_ICFG), .ICFG_BW(ICFG_BW)) u_first (
    .i_mask  (i_cfg_en),
    .i_lo    (i_beg),
    .i_end   (i_end),
    .o_found (first_found),
    .o_id    (first_id)
  );

  chunk_head_pipe_next_cfg_finder #(.N_ICFG(N_ICFG), .ICFG_BW(ICFG_BW)) u_next (
    .i_mask  (i_cfg_en),
    .i_lo    (s1_id_q + ICFG_BW'(1)),
    .i_end   (i_end),
    .o_found (nxt_found),
    .o_id    (nxt_id)
  );

  assign s1_idx = IDX_BW'(s1_id_q);

  // Stage-2 shuffle-accumulate: lanes steering to the same dim add up.
  always_comb begin
    for (int d = 0; d < DIM; d++) begin
      acc[d] = i_global_mofs[s1_idx][d];
      for (int l = 0; l < VDIM; l++) begin
        if (s1_bshuf_q[l] == DIM_BW'(d)) acc[d] = acc[d] + s1_bprod_q[l];
        if (s1_ashuf_q[l] == DIM_BW'(d)) acc[d] = acc[d] + s1_aprod_q[l];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    s1_vld_d    = s1_vld_q;
    s1_id_d     = s1_id_q;
    s1_bprod_d  = s1_bprod_q;
    s1_aprod_d  = s1_aprod_q;
    s1_bshuf_d  = s1_bshuf_q;
    s1_ashuf_d  = s1_ashuf_q;
    mofs_rdy_d  = mofs_rdy_q;
    mofs_d      = mofs_q;
    id_d        = id_q;
    islast_d    = islast_q;
    ld          = 1'b0;
    ld_id       = first_id;
    ld_idx      = '0;
    i_abofs_ack = 1'b0;

    // Stage 1 moves on when the output slot is free or draining this cycle.
    s1_adv = s1_vld_q && (!mofs_rdy_q || o_mofs_ack);
    if (s1_adv) begin
      mofs_rdy_d = 1'b1;
      mofs_d     = acc;
      id_d       = s1_id_q;
      islast_d   = !nxt_found;
      s1_vld_d   = nxt_found;
      ld         = nxt_found;
      ld_id      = nxt_id;
    end else if (o_mofs_ack) begin
      mofs_rdy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (i_abofs_rdy) begin
          if (first_found) begin
            ld       = 1'b1;
            ld_id    = first_id;
            s1_vld_d = 1'b1;
            state_d  = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (o_mofs_ack && mofs_rdy_q && islast_q) begin
          i_abofs_ack = 1'b1;
          state_d     = IDLE;
        end
      end
      DONE: begin
        i_abofs_ack = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      ld_idx     = IDX_BW'(ld_id);
      s1_id_d    = ld_id;
      s1_bshuf_d = i_global_bshufs[ld_idx];
      s1_ashuf_d = i_global_ashufs[ld_idx];
      for (int l = 0; l < VDIM; l++) begin
        s1_bprod_d[l] = scale(i_bofs[l], i_bstrides_frac[ld_idx][l], i_bstrides_shamt[ld_idx][l]);
        s1_aprod_d[l] = scale(i_aofs[l], i_astrides_frac[ld_idx][l], i_astrides_shamt[ld_idx][l]);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s1_bprod_q <= '0;
      s1_aprod_q <= '0;
      s1_bshuf_q <= '0;
      s1_ashuf_q <= '0;
      mofs_rdy_q <= 1'b0;
      mofs_q     <= '0;
      id_q       <= '0;
      islast_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_vld_q   <= s1_vld_d;
      s1_id_q    <= s1_id_d;
      s1_bprod_q <= s1_bprod_d;
      s1_aprod_q <= s1_aprod_d;
      s1_bshuf_q <= s1_bshuf_d;
      s1_ashuf_q <= s1_ashuf_d;
      mofs_rdy_q <= mofs_rdy_d;
      mofs_q     <= mofs_d;
      id_q       <= id_d;
      islast_q   <= islast_d;
    end
  end

  assign o_mofs_rdy = mofs_rdy_q;
  assign o_mofs     = mofs_q;
  assign o_id       = id_q;
  assign o_islast   = islast_q;

endmodule

// File: tb/tb_chunk_head_pipe.sv
// Table-driven scoreboard bench for chunk_head_pipe: range walks, masking, back-pressure, wrap and reset.
module tb_chunk_head_pipe;

  typedef struct {
    logic [2:0]  beg;
    logic [2:0]  fin;
    logic [3:0]  en;
    logic [15:0] b0, b1, a0, a1;
    logic [3:0]  bfr, afr;
    logic [2:0]  bsa, asa;
    logic [1:0]  bm0, bm1, am0, am1;
    logic        gb;
    int          nbeats;
    logic [2:0]  last;
    int          stall_id;
  } rec_t;

  typedef struct {
    logic [3:0][15:0] mofs;
    logic [2:0]       id;
    logic             islast;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                   abofs_rdy, abofs_ack;
  logic [1:0][15:0]       bofs, aofs;
  logic [2:0]             beg, fin;
  logic [3:0]             cfg_en;
  logic [3:0][3:0][15:0]  gmofs;
  logic [3:0][1:0][1:0]   bshufs, ashufs;
  logic [3:0][1:0][3:0]   bfrac, afrac;
  logic [3:0][1:0][2:0]   bsh, ash;
  logic                   mofs_rdy, mofs_ack;
  logic [3:0][15:0]       mofs;
  logic [2:0]             id;
  logic                   islast;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  rec_t tbl[9];

  chunk_head_pipe dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_abofs_rdy      (abofs_rdy),
    .i_abofs_ack      (abofs_ack),
    .i_bofs           (bofs),
    .i_aofs           (aofs),
    .i_beg            (beg),
    .i_end            (fin),
    .i_cfg_en         (cfg_en),
    .i_global_mofs    (gmofs),
    .i_global_bshufs  (bshufs),
    .i_global_ashufs  (ashufs),
    .i_bstrides_frac  (bfrac),
    .i_astrides_frac  (afrac),
    .i_bstrides_shamt (bsh),
    .i_astrides_shamt (ash),
    .o_mofs_rdy       (mofs_rdy),
    .o_mofs_ack       (mofs_ack),
    .o_mofs           (mofs),
    .o_id             (id),
    .o_islast         (islast)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] b, input logic [2:0] e, input logic [3:0] en,
                              input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [3:0] bfr, input logic [2:0] bsa,
                              input logic [3:0] afr, input logic [2:0] asa,
                              input logic [1:0] bm0, input logic [1:0] bm1,
                              input logic [1:0] am0, input logic [1:0] am1,
                              input logic gb, input int nb, input logic [2:0] last, input int stall);
    rec_t r;
    r.beg = b; r.fin = e; r.en = en;
    r.b0 = b0; r.b1 = b1; r.a0 = a0; r.a1 = a1;
    r.bfr = bfr; r.bsa = bsa; r.afr = afr; r.asa = asa;
    r.bm0 = bm0; r.bm1 = bm1; r.am0 = am0; r.am1 = am1;
    r.gb = gb; r.nbeats = nb; r.last = last; r.stall_id = stall;
    return r;
  endfunction

  function automatic logic [15:0] gm_val(input logic gb, input int cid, input int d);
    return gb ? 16'(cid * 256 + d * 16 + 1) : 16'h0;
  endfunction

  function automatic logic [15:0] prod(input logic [15:0] o, input logic [3:0] f, input logic [2:0] s);
    logic [31:0] t;
    t = 32'(o) * 32'(f);
    t = t << s;
    return t[15:0];
  endfunction

  task automatic apply(input rec_t r);
    beg = r.beg; fin = r.fin; cfg_en = r.en;
    bofs[0] = r.b0; bofs[1] = r.b1; aofs[0] = r.a0; aofs[1] = r.a1;
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < 2; l++) begin
        bfrac[c][l] = r.bfr; bsh[c][l] = r.bsa;
        afrac[c][l] = r.afr; ash[c][l] = r.asa;
      end
      bshufs[c][0] = r.bm0; bshufs[c][1] = r.bm1;
      ashufs[c][0] = r.am0; ashufs[c][1] = r.am1;
      for (int d = 0; d < 4; d++) gmofs[c][d] = gm_val(r.gb, c, d);
    end
  endtask

  // Reference model: enumerate the visited ids and compute each expected beat.
  task automatic push_exp(input rec_t r);
    int   ids[$];
    exp_t e;
    logic [15:0] bp0, bp1, ap0, ap1;
    for (int c = int'(r.beg); c < int'(r.fin); c++)
      if (c < 4 && r.en[c]) ids.push_back(c);
    bp0 = prod(r.b0, r.bfr, r.bsa); bp1 = prod(r.b1, r.bfr, r.bsa);
    ap0 = prod(r.a0, r.afr, r.asa); ap1 = prod(r.a1, r.afr, r.asa);
    for (int k = 0; k < ids.size(); k++) begin
      for (int d = 0; d < 4; d++) begin
        e.mofs[d] = gm_val(r.gb, ids[k], d);
        if (int'(r.bm0) == d) e.mofs[d] = e.mofs[d] + bp0;
        if (int'(r.bm1) == d) e.mofs[d] = e.mofs[d] + bp1;
        if (int'(r.am0) == d) e.mofs[d] = e.mofs[d] + ap0;
        if (int'(r.am1) == d) e.mofs[d] = e.mofs[d] + ap1;
      end
      e.id = 3'(ids[k]);
      e.islast = (k == ids.size() - 1);
      q.push_back(e);
    end
  endtask

  // Entered just after a posedge with the DUT idle; leaves just after a posedge, idle again.
  task automatic run_txn(input rec_t r, input int tag);
    int   cyc = 0, beats = 0, stall = 0, first_rdy = -1;
    logic done = 1'b0, pop_last, exp_ack;
    logic [2:0] last_id = 3'd0;
    exp_t f;
    apply(r);
    push_exp(r);
    abofs_rdy = 1'b1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      mofs_ack = 1'b0;
      pop_last = 1'b0;
      if (mofs_rdy) begin
        if (first_rdy < 0) first_rdy = cyc;
        if (q.size() == 0) begin
          chk($sformatf("t%0d_extra_beat", tag), 64'(mofs_rdy), 64'(0));
        end else begin
          f = q[0];
          chk($sformatf("t%0d_o_id", tag), 64'(id), 64'(f.id));
          chk($sformatf("t%0d_o_mofs", tag), 64'(mofs), 64'(f.mofs));
          chk($sformatf("t%0d_o_islast", tag), 64'(islast), 64'(f.islast));
          if (int'(f.id) == r.stall_id && stall < 5) stall++;
          else begin
            mofs_ack = 1'b1;
            pop_last = f.islast;
          end
        end
      end
      #1;
      exp_ack = (r.nbeats == 0) ? (cyc == 1) : pop_last;
      chk($sformatf("t%0d_abofs_ack_c%0d", tag, cyc), 64'(abofs_ack), 64'(exp_ack));
      if (abofs_ack) done = 1'b1;
      @(posedge clk);
      if (mofs_ack && q.size() > 0) begin
        last_id = q[0].id;
        void'(q.pop_front());
        beats++;
      end
      #1;
      mofs_ack = 1'b0;
      if (done) abofs_rdy = 1'b0;
      cyc++;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL t%0d_timeout: got no i_abofs_ack expected ack within 100 cycles", tag);
      abofs_rdy = 1'b0;
    end
    chk($sformatf("t%0d_beats", tag), 64'(beats), 64'(r.nbeats));
    chk($sformatf("t%0d_queue_left", tag), 64'(q.size()), 64'(0));
    chk($sformatf("t%0d_first_rdy_cycle", tag), 64'(first_rdy), (r.nbeats == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(2));
    if (r.nbeats > 0) chk($sformatf("t%0d_last_id", tag), 64'(last_id), 64'(r.last));
    q.delete();
  endtask

  initial begin
    //          beg   end   en       b0        b1        a0     a1     bfr   bsa   afr   asa   bm0   bm1   am0   am1   gb    nb last  stall
    tbl[0] = mk(3'd0, 3'd4, 4'b1111, 16'd1,    16'd2,    16'd0, 16'd0, 4'd1, 3'd0, 4'd1, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4, 3'd3, -1);
    tbl[1] = mk(3'd0, 3'd4, 4'b1010, 16'd1,    16'd2,    16'd0, 16'd0, 4'd1, 3'd0, 4'd1, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2, 3'd3, -1);
    tbl[2] = mk(3'd2, 3'd2, 4'b1111, 16'd1,    16'd2,    16'd0, 16'd0, 4'd1, 3'd0, 4'd1, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 0, 3'd0, -1);
    tbl[3] = mk(3'd0, 3'd4, 4'b0000, 16'd1,    16'd2,    16'd0, 16'd0, 4'd1, 3'd0, 4'd1, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 0, 3'd0, -1);
    tbl[4] = mk(3'd0, 3'd4, 4'b1111, 16'd3,    16'd4,    16'd5, 16'd6, 4'd2, 3'd1, 4'd1, 3'd0, 2'd1, 2'd2, 2'd3, 2'd0, 1'b1, 4, 3'd3, 1);
    tbl[5] = mk(3'd0, 3'd1, 4'b0001, 16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 4'd3, 3'd1, 4'd1, 3'd0, 2'd2, 2'd2, 2'd2, 2'd2, 1'b1, 1, 3'd0, -1);
    tbl[6] = mk(3'd1, 3'd7, 4'b1111, 16'd9,    16'd1,    16'd2, 16'd3, 4'd1, 3'd2, 4'd7, 3'd0, 2'd3, 2'd1, 2'd0, 2'd3, 1'b1, 3, 3'd3, -1);
    tbl[7] = mk(3'd3, 3'd4, 4'b0111, 16'd1,    16'd2,    16'd0, 16'd0, 4'd1, 3'd0, 4'd1, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 0, 3'd0, -1);
    tbl[8] = mk(3'd0, 3'd3, 4'b1111, 16'd5,    16'd7,    16'd3, 16'd9, 4'd2, 3'd2, 4'd5, 3'd1, 2'd3, 2'd0, 2'd1, 2'd3, 1'b1, 3, 3'd2, -1);

    abofs_rdy = 1'b0;
    mofs_ack  = 1'b0;
    apply(tbl[0]);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_mofs_rdy", 64'(mofs_rdy), 64'(0));
    chk("rst_o_mofs", 64'(mofs), 64'(0));
    chk("rst_o_id", 64'(id), 64'(0));
    chk("rst_o_islast", 64'(islast), 64'(0));
    chk("rst_abofs_ack", 64'(abofs_ack), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], i);

    // Reset in the middle of a range walk, then the source re-presents the same range.
    apply(tbl[0]);
    abofs_rdy = 1'b1;
    mofs_ack  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_pre_rdy", 64'(mofs_rdy), 64'(1));
    chk("mid_pre_id", 64'(id), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o_mofs_rdy", 64'(mofs_rdy), 64'(0));
    chk("mid_rst_o_mofs", 64'(mofs), 64'(0));
    chk("mid_rst_o_id", 64'(id), 64'(0));
    chk("mid_rst_o_islast", 64'(islast), 64'(0));
    chk("mid_rst_abofs_ack", 64'(abofs_ack), 64'(0));
    mofs_ack  = 1'b0;
    abofs_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(tbl[0], 90);
    run_txn(tbl[4], 91);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
